// File: rtl/inst_issue_queue_if.sv
// Fetch-to-decode handshake bundle: push side from the I-cache/prediction stage,
// issue side toward the dual decoder.
interface inst_issue_queue_if #(
    parameter int PTR_W = 4
);
    logic             flush;
    logic [1:0]       push_valid;
    logic [31:0]      push_pc;
    logic [31:0]      push_inst0;
    logic [31:0]      push_inst1;
    logic [1:0]       push_pred_taken;
    logic [31:0]      push_pred_target;
    logic             push_ready;
    logic             stall;
    logic             single_req;
    logic [1:0]       issue_valid;
    logic [31:0]      issue_pc0;
    logic [31:0]      issue_pc1;
    logic [31:0]      issue_inst0;
    logic [31:0]      issue_inst1;
    logic [1:0]       issue_pred_taken;
    logic [31:0]      issue_pred_target0;
    logic [31:0]      issue_pred_target1;
    logic [1:0]       issue_in_delayslot;
    logic [PTR_W:0]   count;

    modport master (
        output flush, push_valid, push_pc, push_inst0, push_inst1, push_pred_taken,
               push_pred_target, stall, single_req,
        input  push_ready, issue_valid, issue_pc0, issue_pc1, issue_inst0, issue_inst1,
               issue_pred_taken, issue_pred_target0, issue_pred_target1,
               issue_in_delayslot, count
    );

    modport slave (
        input  flush, push_valid, push_pc, push_inst0, push_inst1, push_pred_taken,
               push_pred_target, stall, single_req,
        output push_ready, issue_valid, issue_pc0, issue_pc1, issue_inst0, issue_inst1,
               issue_pred_taken, issue_pred_target0, issue_pred_target1,
               issue_in_delayslot, count
    );
endinterface

// File: rtl/inst_issue_queue.sv
// Circular instruction queue between fetch and decode; issues one or two
// instructions per cycle under MIPS pairing rules and tags branch delay slots.
module inst_issue_queue #(
    parameter int PTR_W   = 4,
    parameter int ISSUE_W = 2
) (
    input  logic clk,
    input  logic rst,
    inst_issue_queue_if.slave bus
);
    localparam int DEPTH = 1 << PTR_W;
    localparam logic [PTR_W:0] PUSH_LIM = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_tgt  [DEPTH];
    logic             r_pt   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_ds;

    function automatic logic f_is_md(input logic [31:0] w);
        return (w[31:26] == 6'h00 && w[5:0] inside {6'h18, 6'h19, 6'h1a, 6'h1b}) ||
               (w[31:26] == 6'h1c && w[5:0] inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05});
    endfunction

    function automatic logic f_is_br(input logic [31:0] w);
        return (w[31:26] == 6'h00 && w[5:0] inside {6'h08, 6'h09}) ||
               (w[31:26] == 6'h01 && w[20:16] inside {5'h00, 5'h01, 5'h10, 5'h11}) ||
               (w[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07});
    endfunction

    function automatic logic f_is_ls(input logic [31:0] w);
        return w[31:26] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e, 6'h30, 6'h38};
    endfunction

    function automatic logic f_is_trap(input logic [31:0] w);
        return w[31:26] == 6'h00 &&
               w[5:0] inside {6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36, 6'h0c, 6'h0d};
    endfunction

    function automatic logic f_is_priv(input logic [31:0] w);
        return w[31:26] == 6'h10 && (w[25:21] == 5'h00 || w[25:21] == 5'h04) &&
               w[10:3] == 8'h00;
    endfunction

    // Anything that must occupy the issue slot alone, in either lane.
    function automatic logic f_no_pair(input logic [31:0] w);
        return f_is_md(w) || f_is_ls(w) || f_is_trap(w) || f_is_priv(w) ||
               w == 32'h4200_0018 || w == 32'h0000_0040;
    endfunction

    logic [PTR_W-1:0] w_e1;
    logic [PTR_W-1:0] w_tail1;
    logic [31:0]      w_i0;
    logic [31:0]      w_i1;
    logic             w_dual;
    logic [1:0]       w_issue_valid;
    logic [1:0]       w_pop_n;
    logic [1:0]       w_push_n;
    logic             w_push_ok;
    logic             w_last_br;

    assign w_e1    = r_head + 1'b1;
    assign w_tail1 = r_tail + 1'b1;
    assign w_i0    = r_inst[r_head];
    assign w_i1    = r_inst[w_e1];

    assign w_dual = (ISSUE_W == 2) && (r_count >= TWO) && !bus.single_req &&
                    !f_no_pair(w_i0) && !f_no_pair(w_i1) && !f_is_br(w_i1);
    assign w_issue_valid = (r_count == '0) ? 2'b00 : (w_dual ? 2'b11 : 2'b01);
    assign w_pop_n   = bus.stall ? 2'd0 : (w_issue_valid == 2'b11 ? 2'd2 :
                                           (w_issue_valid == 2'b01 ? 2'd1 : 2'd0));
    assign w_push_ok = bus.push_ready && bus.push_valid[0];
    assign w_push_n  = !w_push_ok ? 2'd0 : (bus.push_valid[1] ? 2'd2 : 2'd1);
    assign w_last_br = w_dual ? f_is_br(w_i1) : f_is_br(w_i0);

    assign bus.push_ready         = (r_count <= PUSH_LIM);
    assign bus.count              = r_count;
    assign bus.issue_valid        = w_issue_valid;
    assign bus.issue_pc0          = r_pc[r_head];
    assign bus.issue_pc1          = r_pc[w_e1];
    assign bus.issue_inst0        = w_i0;
    assign bus.issue_inst1        = w_i1;
    assign bus.issue_pred_taken   = {r_pt[w_e1], r_pt[r_head]};
    assign bus.issue_pred_target0 = r_tgt[r_head];
    assign bus.issue_pred_target1 = r_tgt[w_e1];
    assign bus.issue_in_delayslot = {w_dual && f_is_br(w_i0), r_ds};

    // Control state: pointers, occupancy and delay-slot tracking.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ds    <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);
            if (w_pop_n != 2'd0)
                r_ds <= w_last_br;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push_ok && !bus.flush) begin
            r_pc[r_tail]   <= bus.push_pc;
            r_inst[r_tail] <= bus.push_inst0;
            r_pt[r_tail]   <= bus.push_pred_taken[0];
            r_tgt[r_tail]  <= bus.push_pred_target;
            if (bus.push_valid[1]) begin
                r_pc[w_tail1]   <= bus.push_pc + 32'd4;
                r_inst[w_tail1] <= bus.push_inst1;
                r_pt[w_tail1]   <= bus.push_pred_taken[1];
                r_tgt[w_tail1]  <= bus.push_pred_target;
            end
        end
    end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: pairing, delay slots, full/wrap, flush,
// stall hold and a single-issue build.
module tb_inst_issue_queue;
    localparam logic [31:0] ADDU    = 32'h0022_1821;
    localparam logic [31:0] BEQ     = 32'h1022_0004;
    localparam logic [31:0] BNE     = 32'h1422_0004;
    localparam logic [31:0] LW      = 32'h8C22_0000;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] MULT    = 32'h0022_0018;
    localparam logic [31:0] ERET    = 32'h4200_0018;
    localparam logic [31:0] SYSCALL = 32'h0000_000C;
    localparam logic [31:0] MTC0    = 32'h4082_6000;
    localparam logic [31:0] SSNOP   = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_issue_queue_if #(.PTR_W(4)) b0 ();
    inst_issue_queue_if #(.PTR_W(4)) b1 ();

    inst_issue_queue #(.PTR_W(4), .ISSUE_W(2)) u_dut (.clk(clk), .rst(rst), .bus(b0.slave));
    inst_issue_queue #(.PTR_W(4), .ISSUE_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.push_valid = 2'b00; b0.flush = 1'b0; b0.stall = 1'b0; b0.single_req = 1'b0;
        b0.push_pred_taken = 2'b00; b0.push_pred_target = 32'h0;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1);
        b0.push_valid = v; b0.push_pc = pc; b0.push_inst0 = i0; b0.push_inst1 = i1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        b0.push_pc = 0; b0.push_inst0 = 0; b0.push_inst1 = 0;
        b1.flush = 0; b1.push_valid = 0; b1.push_pc = 0; b1.push_inst0 = 0; b1.push_inst1 = 0;
        b1.push_pred_taken = 0; b1.push_pred_target = 0; b1.stall = 0; b1.single_req = 0;
        tick(); tick();
        checks++; if (b0.count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", b0.count); end
        checks++; if (b0.issue_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got %b exp 00", b0.issue_valid); end
        checks++; if (b0.push_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", b0.push_ready); end
        checks++; if (b0.issue_in_delayslot !== 2'b00) begin errors++; $display("FAIL rst_ds got %b exp 00", b0.issue_in_delayslot); end
        rst = 1'b0;
    endtask

    task automatic test_basic_pair();
        idle(); push(2'b11, 32'hBFC0_0000, ADDU, ADDU);
        b0.push_pred_taken = 2'b10; b0.push_pred_target = 32'h1234_5678;
        tick(); idle(); #1;
        checks++; if (b0.issue_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got %b exp 11", b0.issue_valid); end
        checks++; if (b0.issue_pc0 !== 32'hBFC0_0000) begin errors++; $display("FAIL basic_pc0 got %h exp bfc00000", b0.issue_pc0); end
        checks++; if (b0.issue_pc1 !== 32'hBFC0_0004) begin errors++; $display("FAIL basic_pc1 got %h exp bfc00004", b0.issue_pc1); end
        checks++; if (b0.count !== 5'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", b0.count); end
        checks++; if (b0.issue_pred_taken !== 2'b10) begin errors++; $display("FAIL basic_pt got %b exp 10", b0.issue_pred_taken); end
        checks++; if (b0.issue_pred_target1 !== 32'h1234_5678) begin errors++; $display("FAIL basic_tgt1 got %h exp 12345678", b0.issue_pred_target1); end
        tick();
        checks++; if (b0.count !== 5'd0) begin errors++; $display("FAIL basic_drain got %0d exp 0", b0.count); end
    endtask

    task automatic test_delayslot();
        idle(); b0.stall = 1'b1; push(2'b11, 32'h1000, BEQ, ADDU); tick();
        push(2'b11, 32'h1008, ADDU, LW); tick();
        idle(); #1;
        checks++; if (b0.issue_valid !== 2'b11) begin errors++; $display("FAIL ds_c1_valid got %b exp 11", b0.issue_valid); end
        checks++; if (b0.issue_in_delayslot !== 2'b10) begin errors++; $display("FAIL ds_c1_ds got %b exp 10", b0.issue_in_delayslot); end
        tick();
        checks++; if (b0.issue_valid !== 2'b01) begin errors++; $display("FAIL ds_c2_valid got %b exp 01", b0.issue_valid); end
        checks++; if (b0.issue_pc0 !== 32'h1008) begin errors++; $display("FAIL ds_c2_pc got %h exp 1008", b0.issue_pc0); end
        checks++; if (b0.issue_in_delayslot !== 2'b00) begin errors++; $display("FAIL ds_c2_ds got %b exp 00", b0.issue_in_delayslot); end
        tick();
        checks++; if (b0.issue_valid !== 2'b01) begin errors++; $display("FAIL ds_c3_valid got %b exp 01", b0.issue_valid); end
        checks++; if (b0.issue_inst0 !== LW) begin errors++; $display("FAIL ds_c3_inst got %h exp %h", b0.issue_inst0, LW); end
        tick();
        checks++; if (b0.count !== 5'd0) begin errors++; $display("FAIL ds_drain got %0d exp 0", b0.count); end
    endtask

    task automatic test_single_req();
        idle(); b0.stall = 1'b1; push(2'b11, 32'h2000, ADDU, BNE); tick();
        push(2'b01, 32'h2008, NOP, NOP); tick();
        idle(); #1;
        checks++; if (b0.issue_valid !== 2'b01) begin errors++; $display("FAIL sr_addu_valid got %b exp 01", b0.issue_valid); end
        tick();
        checks++; if (b0.issue_valid !== 2'b11) begin errors++; $display("FAIL sr_bne_valid got %b exp 11", b0.issue_valid); end
        checks++; if (b0.issue_in_delayslot !== 2'b10) begin errors++; $display("FAIL sr_bne_ds got %b exp 10", b0.issue_in_delayslot); end
        tick();
        b0.stall = 1'b1; push(2'b11, 32'h3000, ADDU, BNE); tick();
        push(2'b01, 32'h3008, NOP, NOP); tick();
        idle(); b0.single_req = 1'b1; #1;
        checks++; if (b0.issue_valid !== 2'b01) begin errors++; $display("FAIL sr1_a_valid got %b exp 01", b0.issue_valid); end
        tick();
        checks++; if (b0.issue_valid !== 2'b01) begin errors++; $display("FAIL sr1_b_valid got %b exp 01", b0.issue_valid); end
        checks++; if (b0.issue_in_delayslot !== 2'b00) begin errors++; $display("FAIL sr1_b_ds got %b exp 00", b0.issue_in_delayslot); end
        tick();
        checks++; if (b0.issue_pc0 !== 32'h3008) begin errors++; $display("FAIL sr1_c_pc got %h exp 3008", b0.issue_pc0); end
        checks++; if (b0.issue_in_delayslot !== 2'b01) begin errors++; $display("FAIL sr1_c_ds got %b exp 01", b0.issue_in_delayslot); end
        tick();
        checks++; if (b0.issue_in_delayslot !== 2'b00 || b0.count !== 5'd0) begin errors++; $display("FAIL sr1_end got ds %b count %0d exp 00/0", b0.issue_in_delayslot, b0.count); end
        idle();
    endtask

    task automatic test_full_wrap();
        idle(); b0.stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(2'b11, 32'h4000 + 32'(8 * i), ADDU, ADDU); tick();
        end
        checks++; if (b0.push_ready !== 1'b1) begin errors++; $display("FAIL full_ready14 got %b exp 1", b0.push_ready); end
        push(2'b01, 32'h4038, ADDU, ADDU); tick();
        checks++; if (b0.count !== 5'd15) begin errors++; $display("FAIL full_count15 got %0d exp 15", b0.count); end
        checks++; if (b0.push_ready !== 1'b0) begin errors++; $display("FAIL full_ready15 got %b exp 0", b0.push_ready); end
        push(2'b11, 32'hDEAD_0000, NOP, NOP); tick();
        checks++; if (b0.count !== 5'd15) begin errors++; $display("FAIL full_drop got %0d exp 15", b0.count); end
        idle(); b0.single_req = 1'b1; #1;
        checks++; if (b0.issue_pc0 !== 32'h4000) begin errors++; $display("FAIL full_head got %h exp 4000", b0.issue_pc0); end
        tick();
        idle(); push(2'b11, 32'h5000, ADDU, ADDU); #1;
        checks++; if (b0.issue_pc0 !== 32'h4004) begin errors++; $display("FAIL wrap1_pc got %h exp 4004", b0.issue_pc0); end
        tick();
        push(2'b11, 32'h5008, ADDU, ADDU); #1;
        checks++; if (b0.issue_pc0 !== 32'h400C || b0.count !== 5'd14) begin errors++; $display("FAIL wrap2 got pc %h count %0d exp 400c/14", b0.issue_pc0, b0.count); end
        tick();
        idle(); #1;
        checks++; if (b0.issue_pc0 !== 32'h4014 || b0.count !== 5'd14) begin errors++; $display("FAIL wrap3 got pc %h count %0d exp 4014/14", b0.issue_pc0, b0.count); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (b0.issue_pc0 !== 32'h5000 || b0.count !== 5'd4) begin errors++; $display("FAIL wrap_tail got pc %h count %0d exp 5000/4", b0.issue_pc0, b0.count); end
        tick(); tick();
        checks++; if (b0.count !== 5'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", b0.count); end
    endtask

    task automatic test_flush();
        idle(); b0.stall = 1'b1; push(2'b01, 32'h8000, BEQ, NOP); tick();
        idle(); b0.single_req = 1'b1; push(2'b11, 32'h8004, ADDU, ADDU); tick();
        idle(); b0.stall = 1'b1;
        push(2'b11, 32'h800C, ADDU, ADDU); tick();
        push(2'b11, 32'h8014, ADDU, ADDU); tick();
        push(2'b01, 32'h801C, ADDU, ADDU); tick();
        idle(); b0.stall = 1'b1; #1;
        checks++; if (b0.count !== 5'd7) begin errors++; $display("FAIL flush_pre_count got %0d exp 7", b0.count); end
        checks++; if (b0.issue_in_delayslot !== 2'b01) begin errors++; $display("FAIL flush_pre_ds got %b exp 01", b0.issue_in_delayslot); end
        idle(); b0.flush = 1'b1; push(2'b11, 32'h9000, ADDU, ADDU); tick();
        idle(); #1;
        checks++; if (b0.count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", b0.count); end
        checks++; if (b0.issue_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b exp 00", b0.issue_valid); end
        checks++; if (b0.issue_in_delayslot !== 2'b00) begin errors++; $display("FAIL flush_ds got %b exp 00", b0.issue_in_delayslot); end
    endtask

    task automatic test_blocking();
        logic [31:0] la [5];
        logic [31:0] lb [5];
        la = '{MULT, ADDU, SYSCALL, ADDU, SSNOP};
        lb = '{ADDU, ERET, ADDU, MTC0, ADDU};
        for (int i = 0; i < 5; i++) begin
            idle(); b0.stall = 1'b1; push(2'b11, 32'hA000 + 32'(8 * i), la[i], lb[i]); tick();
            idle(); #1;
            checks++; if (b0.issue_valid !== 2'b01) begin errors++; $display("FAIL blk%0d_first got %b exp 01", i, b0.issue_valid); end
            tick();
            checks++; if (b0.issue_valid !== 2'b01 || b0.issue_inst0 !== lb[i]) begin errors++; $display("FAIL blk%0d_second got %b %h exp 01 %h", i, b0.issue_valid, b0.issue_inst0, lb[i]); end
            tick();
        end
    endtask

    task automatic test_issue_w1();
        b1.stall = 1'b1; b1.push_valid = 2'b11; b1.push_pc = 32'h7000;
        b1.push_inst0 = ADDU; b1.push_inst1 = ADDU; tick();
        b1.push_valid = 2'b00; b1.stall = 1'b0; #1;
        checks++; if (b1.issue_valid !== 2'b01) begin errors++; $display("FAIL w1_first got %b exp 01", b1.issue_valid); end
        tick();
        checks++; if (b1.issue_valid !== 2'b01 || b1.issue_pc0 !== 32'h7004) begin errors++; $display("FAIL w1_second got %b %h exp 01 7004", b1.issue_valid, b1.issue_pc0); end
        tick();
        checks++; if (b1.issue_valid !== 2'b00) begin errors++; $display("FAIL w1_empty got %b exp 00", b1.issue_valid); end
    endtask

    task automatic test_stall();
        idle(); b0.stall = 1'b1; push(2'b11, 32'h6000, ADDU, ADDU); tick();
        push(2'b11, 32'h6008, ADDU, ADDU); tick();
        idle(); b0.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b0.count !== 5'd4 || b0.issue_valid !== 2'b11 || b0.issue_pc0 !== 32'h6000) begin errors++; $display("FAIL stall%0d got count %0d valid %b pc %h exp 4/11/6000", i, b0.count, b0.issue_valid, b0.issue_pc0); end
            tick();
        end
        idle(); tick();
        checks++; if (b0.issue_pc0 !== 32'h6008 || b0.count !== 5'd2) begin errors++; $display("FAIL stall_release got pc %h count %0d exp 6008/2", b0.issue_pc0, b0.count); end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks++; if (b0.count !== 5'd0 || b0.issue_valid !== 2'b00) begin errors++; $display("FAIL midrst got count %0d valid %b exp 0/00", b0.count, b0.issue_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_delayslot();
        test_single_req();
        test_full_wrap();
        test_flush();
        test_blocking();
        test_issue_w1();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before end of sequence");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_issue_queue.md
# inst_issue_queue

Parametrised fetch-to-decode instruction queue that decouples the I-cache fetch stage from decode and generalises next-PC single/dual-issue pairing into a buffered, depth-configurable block. It accepts up to two instructions per cycle, stores them with their branch prediction, and issues up to ISSUE_W per cycle under the MIPS pairing rules. Issued instructions are tagged with delay-slot status. The block sits between the I-cache/prediction stage and the dual decoder and is cleared on pipeline flush.

## Interface
- PTR_W, 4, pointer width; DEPTH = 2**PTR_W entries (min PTR_W = 2)
- ISSUE_W, 2, maximum instructions issued per cycle (1 or 2); 1 forces permanent single issue
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries and delay-slot state
- push_valid  in  2  lane mask; legal values 00, 01, 11
- push_pc  in  32  PC of lane 0; lane 1 PC = push_pc + 4
- push_inst0, push_inst1  in  32 each  instruction words
- push_pred_taken  in  2  per-lane predicted-taken bit
- push_pred_target  in  32  predicted target, stored with both lanes
- push_ready  out  1  free entries >= 2
- stall  in  1  decode stalled; no pop
- single_req  in  1  cache/debug request to issue at most one this cycle
- issue_valid  out  2  lane mask of issued entries (00, 01, 11)
- issue_pc0, issue_pc1  out  32 each
- issue_inst0, issue_inst1  out  32 each
- issue_pred_taken  out  2; issue_pred_target0/1  out  32 each
- issue_in_delayslot  out  2  lane is a branch delay slot
- count  out  PTR_W+1  occupied entries

## Operation
- Circular buffer; head/tail pointers PTR_W bits, wrap modulo DEPTH; count tracked separately (0..DEPTH).
- Push: when push_ready and push_valid != 00, write 1 or 2 entries at tail, tail += popcount(push_valid). Push while !push_ready is dropped (upstream protocol violation, no corruption).
- Class decode of head entries (e0 = head, e1 = head+1):
  - md: SPECIAL funct MULT/MULTU/DIV/DIVU; SPECIAL2 MUL/MADD/MADDU/MSUB/MSUBU.
  - br: SPECIAL JR/JALR; REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL; opcode J/JAL/BEQ/BNE/BLEZ/BGTZ.
  - ls: LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW/SWL/SWR/LL/SC.
  - trap: SPECIAL TEQ/TGE/TGEU/TLT/TLTU/TNE/SYSCALL/BREAK.
  - priv: COP0 with rs = 00000 or 00100 and bits[10:3] = 0; eret: word = ERET; ssnop: word = SSNOP.
- dual_ok = ISSUE_W==2 and count>=2 and !single_req and neither entry is md/ls/trap/priv/eret/ssnop and e1 is not br.
- issue_valid = 00 if count==0; 01 if count>=1 and !dual_ok; 11 if dual_ok.
- Pop when !stall: head += popcount(issue_valid), count updated. Outputs remain valid regardless of stall; decode samples only when !stall.
- Delay-slot state: register ds_pending. issue_in_delayslot[0] = ds_pending; issue_in_delayslot[1] = e0 is br (dual only).
  - On a pop: ds_pending <= (last popped entry is br).
  - Flush/reset: ds_pending <= 0.
- Simultaneous push and pop: both applied; count += pushed - popped. Full queue with pop still rejects push that cycle (push_ready is based on registered count).
- Flush beats push and pop: head = tail = 0, count = 0.
- Lane 1 issue fields are don't-care when issue_valid[1] = 0.

## Timing
- Reset/flush values: count 0, head 0, tail 0, ds_pending 0, issue_valid 00, push_ready 1, all issue_in_delayslot 0.
- Push-to-issue latency 1 cycle; an entry written at edge N can be issued in cycle N+1.
- push_ready and count are registered-state functions; issue_* outputs are combinational from stored entries, count, ds_pending and single_req.
- Throughput: 2 instructions per cycle sustained when pairs are dual-eligible.
- rst asserted mid-stream: all state cleared at that edge; contents are ignored afterward.

## Test plan
- Reset, push pair ADDU/ADDU at PC 0xBFC00000 -> next cycle issue_valid 11, issue_pc0 0xBFC00000, issue_pc1 0xBFC00004, count 2 -> 0 after pop.
- Push BEQ+ADDU, then ADDU+LW -> cycle 1 dual with issue_in_delayslot 10; cycle 2 ADDU single (LW pairing blocked), ds_pending 0; cycle 3 LW single.
- Push ADDU+BNE, then NOP -> ADDU single; BNE+NOP dual with in_delayslot 10; single_req=1 variant: BNE single, then NOP with in_delayslot 01.
- Fill DEPTH=16 without pops -> push_ready 0 at count 15/16; dropped push does not advance tail; pop 2 and push 2 in the same cycle keeps count constant across pointer wrap 15->0.
- MULT at head with any partner, and ERET/SYSCALL/MTC0/SSNOP in either lane -> issue_valid 01 each cycle; ISSUE_W=1 build -> never 11.
- Flush with count 7 and simultaneous push -> next cycle count 0, issue_valid 00, ds_pending 0; stall=1 for 3 cycles -> head and count unchanged while outputs are held.
